// File: rtl/boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// boot_loader_pkg : shared constants and state encodings for the boot loader
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package boot_loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      WAIT_SYNC = 3'd0,
      GET_LEN   = 3'd1,
      GET_DATA  = 3'd2,
      GET_CSUM  = 3'd3,
      DONE      = 3'd4,
      ERR       = 3'd5
   } load_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/boot_loader_uart_rx.sv
// ---------------------------------------------------------------------------
// boot_loader_uart_rx : 8N1 UART receiver with 2-FF input synchroniser
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module boot_loader_uart_rx
   import boot_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       rx_valid,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   logic          sync1;
   logic          sync2;
   logic          sync_prev;
   rx_state_t     state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_idx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         sync_prev <= 1'b1;
         state     <= RX_IDLE;
         clk_cnt   <= '0;
         bit_idx   <= 3'd0;
         data      <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         sync1     <= rx;
         sync2     <= sync1;
         sync_prev <= sync2;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         clk_cnt   <= clk_cnt + CW'(1);
         case (state)
            RX_IDLE: begin
               clk_cnt <= '0;
               // Only a genuine high-to-low edge starts a byte, so a line held
               // low after a framing error cannot retrigger the receiver.
               if (sync_prev && !sync2) state <= RX_START;
            end
            RX_START: begin
               if (clk_cnt == CW'(CLKS_PER_BIT/2 - 1)) begin
                  clk_cnt <= '0;
                  bit_idx <= 3'd0;
                  state   <= sync2 ? RX_IDLE : RX_DATA;
               end
            end
            RX_DATA: begin
               if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                  clk_cnt <= '0;
                  data    <= {sync2, data[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                  rx_valid  <= sync2;
                  frame_err <= !sync2;
                  state     <= RX_IDLE;
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader : framed UART program loader writing RAM and holding the CPU
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int TIMEOUT      = 4096
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] ram_addr,
   output logic [7:0] ram_data,
   output logic       ram_we,
   output logic       cpu_hold,
   output logic       done,
   output logic       error
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        frame_err;
   load_state_t state;
   logic [8:0]  count;
   logic [7:0]  sum;
   logic [TW-1:0] timer;
   logic        in_frame;

   boot_loader_uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_rx (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .data      (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err)
   );

   assign in_frame = (state == GET_LEN) || (state == GET_DATA) || (state == GET_CSUM);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= WAIT_SYNC;
         count    <= 9'd0;
         sum      <= 8'h00;
         timer    <= '0;
         ram_addr <= 8'h00;
         ram_data <= 8'h00;
         ram_we   <= 1'b0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         ram_we <= 1'b0;
         if (ram_we) ram_addr <= ram_addr + 8'd1;

         // timer holds the number of cycles elapsed since the last byte
         if (rx_valid)      timer <= TW'(1);
         else if (in_frame) timer <= timer + TW'(1);

         if (frame_err && state != DONE) begin
            state <= ERR;
            error <= 1'b1;
         end else if (rx_valid) begin
            case (state)
               WAIT_SYNC, ERR: begin
                  if (rx_data == SYNC_BYTE) begin
                     state    <= GET_LEN;
                     error    <= 1'b0;
                     ram_addr <= 8'h00;
                     sum      <= 8'h00;
                  end
               end
               GET_LEN: begin
                  count <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                  state <= GET_DATA;
               end
               GET_DATA: begin
                  ram_data <= rx_data;
                  ram_we   <= 1'b1;
                  sum      <= sum + rx_data;
                  count    <= count - 9'd1;
                  if (count == 9'd1) state <= GET_CSUM;
               end
               GET_CSUM: begin
                  if (rx_data == sum) begin
                     state    <= DONE;
                     cpu_hold <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
               default: ;
            endcase
         end else if (in_frame && timer == TW'(TIMEOUT - 1)) begin
            state <= ERR;
            error <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire
